// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO controller: SRL storage addressed by occupancy, with an
// optional show-ahead output register and sticky overflow/underflow flags.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int REG_OUT    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic                  if_almost_full,
    output logic                  err_overflow,
    output logic                  err_underflow,
    input  logic                  clear_err
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [DATA_WIDTH-1:0] srl_head;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  push;
    logic                  pop;
    logic                  deq;
    logic                  v;
    logic                  ovf_set;
    logic                  unf_set;

    assign if_full_n = (cnt != FULL_CNT);
    assign push      = if_write_ce & if_write & if_full_n;
    assign pop       = if_read_ce & if_read & if_empty_n;
    assign ovf_set   = if_write_ce & if_write & ~if_full_n;
    assign unf_set   = if_read_ce & if_read & ~if_empty_n;

    // Oldest entry sits at index cnt-1; clamp at empty so the address stays in range.
    assign rd_addr  = (cnt == '0) ? '0 : ADDR_WIDTH'(cnt - 1'b1);
    assign srl_head = srl[rd_addr];

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl[i] <= srl[i-1];
            end
            srl[0] <= if_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (push && !deq) begin
            cnt <= cnt + 1'b1;
        end else if (!push && deq) begin
            cnt <= cnt - 1'b1;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  v_q;

            // Refill the output register whenever it is empty or being consumed.
            assign deq = (!v_q || pop) && (cnt != '0);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q <= '0;
                    v_q    <= 1'b0;
                end else if (deq) begin
                    dout_q <= srl_head;
                    v_q    <= 1'b1;
                end else if (pop) begin
                    v_q    <= 1'b0;
                end
            end

            assign v          = v_q;
            assign if_empty_n = v_q;
            assign if_dout    = dout_q;
        end else begin : g_direct_out
            assign deq        = pop;
            assign v          = 1'b0;
            assign if_empty_n = (cnt != '0);
            assign if_dout    = srl_head;
        end
    endgenerate

    assign if_num_data_valid = cnt + {{ADDR_WIDTH{1'b0}}, v};
    assign if_almost_full    = (int'(if_num_data_valid) >= AF_LEVEL);

    // A new error in the same cycle as clear_err wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= ovf_set | (err_overflow & ~clear_err);
            err_underflow <= unf_set | (err_underflow & ~clear_err);
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl: a direct-output instance and a
// registered-output instance, both DEPTH=4.
module tb_srl_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       a_wce = 0, a_w = 0, a_rce = 0, a_r = 0, a_clr = 0;
    logic [7:0] a_din = '0;
    logic       a_full_n, a_empty_n, a_af, a_ovf, a_unf;
    logic [7:0] a_dout;
    logic [2:0] a_num;

    logic       b_wce = 0, b_w = 0, b_rce = 0, b_r = 0, b_clr = 0;
    logic [7:0] b_din = '0;
    logic       b_full_n, b_empty_n, b_af, b_ovf, b_unf;
    logic [7:0] b_dout;
    logic [2:0] b_num;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_LEVEL(2), .REG_OUT(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(a_wce), .if_write(a_w), .if_din(a_din), .if_full_n(a_full_n),
        .if_read_ce(a_rce), .if_read(a_r), .if_dout(a_dout), .if_empty_n(a_empty_n),
        .if_num_data_valid(a_num), .if_almost_full(a_af),
        .err_overflow(a_ovf), .err_underflow(a_unf), .clear_err(a_clr)
    );

    srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_LEVEL(2), .REG_OUT(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(b_wce), .if_write(b_w), .if_din(b_din), .if_full_n(b_full_n),
        .if_read_ce(b_rce), .if_read(b_r), .if_dout(b_dout), .if_empty_n(b_empty_n),
        .if_num_data_valid(b_num), .if_almost_full(b_af),
        .err_overflow(b_ovf), .err_underflow(b_unf), .clear_err(b_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic en, input logic [7:0] d);
        a_wce = en; a_w = en; a_din = d;
    endtask

    task automatic a_rd(input logic en);
        a_rce = en; a_r = en;
    endtask

    logic [7:0] b_exp [4];

    initial begin
        b_exp[0] = 8'h78; b_exp[1] = 8'h79; b_exp[2] = 8'h7A; b_exp[3] = 8'h7B;

        // Reset values, held without any clock edge
        #2;
        chk("rst_full_n", a_full_n, 1);
        chk("rst_empty_n", a_empty_n, 0);
        chk("rst_num", a_num, 0);
        chk("rst_af", a_af, 0);
        chk("rst_errs", {a_ovf, a_unf}, 0);
        chk("rst_b_dout", b_dout, 0);
        chk("rst_b_empty_n", b_empty_n, 0);
        #10 reset_n = 1'b1;

        // Basic ordering
        a_wr(1, 8'h11); tick();
        chk("ord_num1", a_num, 1);
        chk("ord_empty_n1", a_empty_n, 1);
        chk("ord_dout1", a_dout, 8'h11);
        chk("ord_af1", a_af, 0);
        a_wr(1, 8'h22); tick();
        chk("ord_af2", a_af, 1);
        a_wr(1, 8'h33); tick();
        chk("ord_num3", a_num, 3);
        chk("ord_head", a_dout, 8'h11);
        a_wr(0, 8'h00); a_rd(1);
        tick(); chk("ord_pop1", a_dout, 8'h22);
        tick(); chk("ord_pop2", a_dout, 8'h33);
        chk("ord_num_after2", a_num, 1);
        tick(); chk("ord_empty", a_empty_n, 0);
        chk("ord_num0", a_num, 0);
        a_rd(0);

        // Fill to full, fifth write dropped
        for (int i = 0; i < 5; i++) begin
            a_wr(1, 8'hA0 + 8'(i)); tick();
            if (i == 0) chk("fill_af_c1", a_af, 0);
            if (i == 1) chk("fill_af_c2", a_af, 1);
            if (i == 3) begin
                chk("fill_full_n", a_full_n, 0);
                chk("fill_num4", a_num, 4);
                chk("fill_no_ovf", a_ovf, 0);
            end
        end
        chk("fill_ovf", a_ovf, 1);
        chk("fill_num_hold", a_num, 4);
        chk("fill_head", a_dout, 8'hA0);

        // Push and pop together while full: only the pop happens
        a_wr(1, 8'hEE); a_rd(1); tick();
        chk("full_pp_num", a_num, 3);
        chk("full_pp_dout", a_dout, 8'hA1);
        a_wr(0, 8'h00); tick();
        chk("pp_pre_num", a_num, 2);
        chk("pp_pre_dout", a_dout, 8'hA2);
        a_wr(1, 8'hC3); tick();
        chk("pp_num", a_num, 2);
        chk("pp_dout", a_dout, 8'hA3);
        a_wr(0, 8'h00); tick();
        chk("pp_tail", a_dout, 8'hC3);
        tick();
        chk("pp_drained", a_empty_n, 0);

        // Push with pop while empty: no bypass, underflow flagged
        a_wr(1, 8'h5C); tick();
        chk("emp_unf", a_unf, 1);
        chk("emp_num", a_num, 1);
        chk("emp_dout", a_dout, 8'h5C);
        a_wr(0, 8'h00); tick();
        chk("emp_drain", a_num, 0);
        a_rd(0);

        // Error clear behaviour
        a_clr = 1; tick();
        chk("clr_both", {a_ovf, a_unf}, 0);
        tick();
        chk("clr_idle", {a_ovf, a_unf}, 0);
        a_clr = 0;
        for (int i = 0; i < 4; i++) begin
            a_wr(1, 8'hD0 + 8'(i)); tick();
        end
        a_clr = 1; a_wr(1, 8'hDD); tick();
        chk("clr_vs_ovf", a_ovf, 1);
        a_wr(0, 8'h00); tick();
        chk("clr_after", a_ovf, 0);
        a_clr = 0;

        // Mid-operation asynchronous reset
        a_rd(1); tick(); a_rd(0);
        chk("mid_num3", a_num, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_num", a_num, 0);
        chk("mid_rst_empty_n", a_empty_n, 0);
        chk("mid_rst_full_n", a_full_n, 1);
        chk("mid_rst_af", a_af, 0);
        #1 reset_n = 1'b1;
        a_wr(1, 8'h5A); tick(); a_wr(0, 8'h00);
        chk("mid_post_num", a_num, 1);
        chk("mid_post_dout", a_dout, 8'h5A);
        a_rd(1); tick(); a_rd(0);
        chk("mid_post_empty", a_empty_n, 0);

        // Registered output: first-word latency and capacity DEPTH+1
        b_wce = 1; b_w = 1; b_din = 8'h77; tick();
        chk("ro_lat_t1", b_empty_n, 0);
        chk("ro_num_t1", b_num, 1);
        b_wce = 0; b_w = 0; tick();
        chk("ro_lat_t2", b_empty_n, 1);
        chk("ro_dout", b_dout, 8'h77);
        for (int i = 0; i < 4; i++) begin
            b_wce = 1; b_w = 1; b_din = b_exp[i]; tick();
        end
        b_wce = 0; b_w = 0;
        chk("ro_num5", b_num, 5);
        chk("ro_full_n", b_full_n, 0);
        chk("ro_af", b_af, 1);
        chk("ro_head", b_dout, 8'h77);
        b_rce = 1; b_r = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ro_pop_dout", b_dout, 32'(b_exp[k]));
            chk("ro_pop_num", b_num, 32'(4 - k));
        end
        tick();
        chk("ro_empty", b_empty_n, 0);
        chk("ro_num0", b_num, 0);
        b_rce = 0; b_r = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/srl_fifo_ctrl.md
SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: SRL read-address width.
REQ-003 SHALL have parameter DEPTH, default 16: SRL capacity, legal range 2..2^ADDR_WIDTH.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold, in entries.
REQ-005 SHALL have parameter REG_OUT, default 0: 0 selects SRL-addressed output, 1 adds a show-ahead output register.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have ports if_write_ce and if_write, inputs, 1 each: write enable pair.
REQ-009 SHALL have port if_din, input, DATA_WIDTH: write data.
REQ-010 SHALL have port if_full_n, output, 1: high when a write can be accepted.
REQ-011 SHALL have ports if_read_ce and if_read, inputs, 1 each: read enable pair.
REQ-012 SHALL have port if_dout, output, DATA_WIDTH: head-of-queue data.
REQ-013 SHALL have port if_empty_n, output, 1: high when if_dout is valid.
REQ-014 SHALL have port if_num_data_valid, output, ADDR_WIDTH+1: total entries held.
REQ-015 SHALL have port if_almost_full, output, 1: occupancy at or above the threshold.
REQ-016 SHALL have ports err_overflow and err_underflow, outputs, 1 each: sticky error flags.
REQ-017 SHALL have port clear_err, input, 1: synchronous clear for both error flags.

Function
REQ-018 SHALL define push = if_write_ce & if_write & if_full_n, and pop = if_read_ce & if_read & if_empty_n.
REQ-019 SHALL store data in an SRL array that, on push, shifts every entry up one place and loads if_din into entry 0; array contents are not reset.
REQ-020 SHALL keep an SRL count N in 0..DEPTH: +1 on push only, -1 on SRL dequeue only, unchanged when both occur or neither occurs.
REQ-021 SHALL drive if_full_n = (N != DEPTH), derived combinationally from registered state only.
REQ-022 (REG_OUT=0) SHALL make SRL dequeue equal pop, drive if_empty_n = (N != 0), and drive if_dout = SRL[N-1]; if_dout is don't-care while if_empty_n = 0.
REQ-023 (REG_OUT=0) SHALL, on simultaneous push and pop with 0<N<DEPTH, keep N unchanged and present the next-oldest entry on if_dout in the following cycle.
REQ-024 (REG_OUT=1) SHALL hold an output register with a valid bit V: when (V=0 or pop) and N>0, load SRL[N-1] and set V=1 (this is the SRL dequeue); when pop and N=0, clear V.
REQ-025 (REG_OUT=1) SHALL drive if_empty_n = V and if_dout from the output register; total capacity is DEPTH+1.
REQ-026 SHALL drive if_num_data_valid = N + V, with V taken as 0 when REG_OUT=0.
REQ-027 SHALL drive if_almost_full = (if_num_data_valid >= AF_LEVEL).
REQ-028 SHALL provide first-word latency from the push edge to if_empty_n=1 of 1 cycle for REG_OUT=0 and 2 cycles for REG_OUT=1.
REQ-029 SHALL block writes while full; a pop in the same cycle SHALL NOT admit a write, because if_full_n does not look ahead.
REQ-030 SHALL block reads while empty; a push in the same cycle SHALL NOT bypass to if_dout.
REQ-031 SHALL set err_overflow when if_write_ce & if_write & !if_full_n, and err_underflow when if_read_ce & if_read & !if_empty_n.
REQ-032 SHALL clear both error flags on clear_err, except that a same-cycle set takes priority over the clear.

Reset
REQ-033 SHALL, while reset_n=0 and regardless of clk, force N=0, V=0, if_full_n=1, if_empty_n=0, if_num_data_valid=0, if_almost_full=0 (AF_LEVEL>0), and both error flags to 0.
REQ-034 SHALL force the output register to 0 under reset when REG_OUT=1.
REQ-035 SHALL, on reset asserted mid-operation, discard all queued data; the first pop after release returns only data pushed after release.

Verification
REQ-036 Basic order: REG_OUT=0, DEPTH=4; push 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> if_dout reads 0x11,0x22,0x33, then if_empty_n=0 and if_num_data_valid=0.
REQ-037 Fill to full: REG_OUT=0, DEPTH=4; 5 pushes -> if_full_n=0 after the 4th, the 5th is dropped and sets err_overflow=1, and if_almost_full=1 from count 2 onward.
REQ-038 Simultaneous push/pop: REG_OUT=0, N=2 holding A,B; push C while popping -> N=2 and the next if_dout=B; simultaneous push/pop at N=4 -> pop only, N=3.
REQ-039 Registered output: REG_OUT=1, DEPTH=4; single push at cycle t -> if_empty_n=1 at t+2; 5 pushes without reads -> if_num_data_valid=5, if_full_n=0.
REQ-040 Errors and clear: pop while empty -> err_underflow=1; clear_err with no error -> both flags 0; clear_err coinciding with a new overflow -> err_overflow stays 1.
REQ-041 Mid-operation reset: with N=3, pulse reset_n low between clock edges -> outputs take reset values immediately; after release, push 0x5A then pop -> if_dout=0x5A.
